seq_alu: RTL and testbench

Parametrised multi-cycle ALU; successor to the single-cycle RV32I ALU. Single-cycle integer ops plus iterative RV32M multiply and divide behind a valid/ready handshake. Sits in the execute stage; the pipeline stalls on `in_ready`/`out_valid`. Branch/PC adders stay in the execute stage and are out of scope.

---
 rtl/seq_alu_pkg.sv | 57 +++++
 rtl/seq_alu_if.sv | 32 +++
 rtl/seq_alu_div.sv | 64 ++++++
 rtl/seq_alu.sv | 196 +++++++++++++++++++
 tb/tb_seq_alu.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_pkg
// Purpose  : Op-code constants, FSM state encoding and op-class predicates
//            shared by the seq_alu RTL and its testbench.
// Revision : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    localparam logic [4:0] C_OP_ADD    = 5'd0;
    localparam logic [4:0] C_OP_SUB    = 5'd1;
    localparam logic [4:0] C_OP_AND    = 5'd2;
    localparam logic [4:0] C_OP_OR     = 5'd3;
    localparam logic [4:0] C_OP_XOR    = 5'd4;
    localparam logic [4:0] C_OP_SLL    = 5'd5;
    localparam logic [4:0] C_OP_SRL    = 5'd6;
    localparam logic [4:0] C_OP_SRA    = 5'd7;
    localparam logic [4:0] C_OP_SLT    = 5'd8;
    localparam logic [4:0] C_OP_SLTU   = 5'd9;
    localparam logic [4:0] C_OP_MUL    = 5'd10;
    localparam logic [4:0] C_OP_MULH   = 5'd11;
    localparam logic [4:0] C_OP_MULHSU = 5'd12;
    localparam logic [4:0] C_OP_MULHU  = 5'd13;
    localparam logic [4:0] C_OP_DIV    = 5'd14;
    localparam logic [4:0] C_OP_DIVU   = 5'd15;
    localparam logic [4:0] C_OP_REM    = 5'd16;
    localparam logic [4:0] C_OP_REMU   = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_mul(input logic [4:0] op);
        return (op == C_OP_MUL) || (op == C_OP_MULH) ||
               (op == C_OP_MULHSU) || (op == C_OP_MULHU);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op == C_OP_DIV) || (op == C_OP_DIVU) ||
               (op == C_OP_REM) || (op == C_OP_REMU);
    endfunction

    // MUL works on unsigned magnitudes: its low half is sign-agnostic
    function automatic logic is_signed_a(input logic [4:0] op);
        return (op == C_OP_MULH) || (op == C_OP_MULHSU) ||
               (op == C_OP_DIV) || (op == C_OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [4:0] op);
        return (op == C_OP_MULH) || (op == C_OP_DIV) || (op == C_OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_if
// Purpose  : Request/response handshake bundle between the execute stage
//            (master) and seq_alu (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu_div.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_div
// Purpose  : Iterative restoring divider on unsigned magnitudes; one quotient
//            bit per cycle, WIDTH cycles after start. o_quot/o_rem show the
//            post-step values so the caller can register them on o_done.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the trial
    assign w_trial = {r_rem, r_quot[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_div};
    assign w_qbit  = ~w_diff[WIDTH];
    assign o_rem   = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_quot  = {r_quot[WIDTH-2:0], w_qbit};
    assign o_done  = r_busy && (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_busy <= !o_done;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_start) begin
            r_rem  <= '0;
            r_quot <= i_dividend;
            r_div  <= i_divisor;
        end else if (r_busy) begin
            r_rem  <= o_rem;
            r_quot <= o_quot;
        end
    end
endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Multi-cycle RV32IM ALU: single-cycle integer ops, shift-add
//            multiply and (with SEQ_ALU_DIV_EN defined) restoring divide.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [4:0]         r_op;
    logic               r_neg;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_illegal;

    logic               w_accept;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [CNT_W-1:0]   w_shamt;
    logic [WIDTH-1:0]   w_imm_res;
    logic               w_imm_ill;
    logic               w_go_mul;
    logic               w_go_div;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_mul_res;
    logic               w_mul_last;
    logic               w_div_done;
    logic               w_div_last;
    logic [WIDTH-1:0]   w_div_res;

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);
    assign w_neg_a  = is_signed_a(bus.op) && bus.a[WIDTH-1];
    assign w_neg_b  = is_signed_b(bus.op) && bus.b[WIDTH-1];
    assign w_mag_a  = w_neg_a ? -bus.a : bus.a;
    assign w_mag_b  = w_neg_b ? -bus.b : bus.b;
    assign w_shamt  = bus.b[CNT_W-1:0];

`ifdef SEQ_ALU_DIV_EN
    logic             r_neg_a;
    logic             w_div_ovf;
    logic [WIDTH-1:0] w_div_quot;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_div_ovf = ((bus.op == C_OP_DIV) || (bus.op == C_OP_REM)) &&
                       (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);

    seq_alu_div #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_accept && w_go_div),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_done     (w_div_done),
        .o_quot     (w_div_quot),
        .o_rem      (w_div_rem)
    );

    // Remainder takes the dividend's sign; quotient is negative on sign mismatch
    assign w_quot_fix = r_neg   ? -w_div_quot : w_div_quot;
    assign w_rem_fix  = r_neg_a ? -w_div_rem  : w_div_rem;
    assign w_div_res  = ((r_op == C_OP_REM) || (r_op == C_OP_REMU)) ? w_rem_fix : w_quot_fix;
`else
    assign w_div_done = 1'b0;
    assign w_div_res  = '0;
`endif

    always_comb begin
        w_imm_res = '0;
        w_imm_ill = 1'b0;
        w_go_mul  = 1'b0;
        w_go_div  = 1'b0;
        if (is_mul(bus.op)) begin
            w_go_mul = 1'b1;
`ifdef SEQ_ALU_DIV_EN
        end else if (is_div(bus.op)) begin
            if (bus.b == '0)
                w_imm_res = ((bus.op == C_OP_DIV) || (bus.op == C_OP_DIVU)) ? '1 : bus.a;
            else if (w_div_ovf)
                w_imm_res = (bus.op == C_OP_DIV) ? bus.a : '0;
            else
                w_go_div = 1'b1;
`endif
        end else begin
            case (bus.op)
                C_OP_ADD:  w_imm_res = bus.a + bus.b;
                C_OP_SUB:  w_imm_res = bus.a - bus.b;
                C_OP_AND:  w_imm_res = bus.a & bus.b;
                C_OP_OR:   w_imm_res = bus.a | bus.b;
                C_OP_XOR:  w_imm_res = bus.a ^ bus.b;
                C_OP_SLL:  w_imm_res = bus.a << w_shamt;
                C_OP_SRL:  w_imm_res = bus.a >> w_shamt;
                C_OP_SRA:  w_imm_res = $signed(bus.a) >>> w_shamt;
                C_OP_SLT:  w_imm_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
                C_OP_SLTU: w_imm_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
                default:   w_imm_ill = 1'b1;
            endcase
        end
    end

    // Shift-add step: conditionally add multiplicand to the high half, shift right
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_nxt  = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_mul_res  = (r_op == C_OP_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
    assign w_mul_last = (r_state == ST_MUL) && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_div_last = (r_state == ST_DIV) && w_div_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = (r_state == ST_IDLE);
        bus.out_valid = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE: if (bus.in_valid)
                         w_state_nxt = w_go_mul ? ST_MUL : (w_go_div ? ST_DIV : ST_DONE);
            ST_MUL:  if (w_mul_last)    w_state_nxt = ST_DONE;
            ST_DIV:  if (w_div_done)    w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_accept)
            r_cnt <= '0;
        else if (r_state == ST_MUL)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= bus.op;
            r_neg   <= w_neg_a ^ w_neg_b;
            r_mcand <= w_mag_a;
            r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
`ifdef SEQ_ALU_DIV_EN
            r_neg_a <= w_neg_a;
`endif
        end else if (r_state == ST_MUL) begin
            r_acc <= w_acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept && !w_go_mul && !w_go_div) begin
            r_result  <= w_imm_res;
            r_zero    <= (w_imm_res == '0);
            r_illegal <= w_imm_ill;
        end else if (w_mul_last) begin
            r_result  <= w_mul_res;
            r_zero    <= (w_mul_res == '0);
            r_illegal <= 1'b0;
        end else if (w_div_last) begin
            r_result  <= w_div_res;
            r_zero    <= (w_div_res == '0);
            r_illegal <= 1'b0;
        end
    end

    assign bus.result  = r_result;
    assign bus.zero    = r_zero;
    assign bus.illegal = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Purpose  : Scoreboard bench for seq_alu (WIDTH=32): randomized and directed
//            ops checked against a 64-bit arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ill;
        int           lat;
        int           acc;
    } exp_t;

    logic   clk    = 1'b0;
    logic   rst_n  = 1'b0;
    int     cyc    = 0;
    int     n_vec  = 0;
    int     n_bad  = 0;
    int     stall_next = 0;
    exp_t   q[$];

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: RV32IM semantics evaluated with 64-bit integer arithmetic
    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        longint       sa;
        longint       sb;
        logic [63:0]  p;
        logic [4:0]   sh;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        sh    = b[4:0];
        p     = '0;
        e.res = '0;
        e.ill = 1'b0;
        e.lat = 1;
        e.acc = 0;
        case (op)
            C_OP_ADD:    e.res = a + b;
            C_OP_SUB:    e.res = a - b;
            C_OP_AND:    e.res = a & b;
            C_OP_OR:     e.res = a | b;
            C_OP_XOR:    e.res = a ^ b;
            C_OP_SLL:    e.res = a << sh;
            C_OP_SRL:    e.res = a >> sh;
            C_OP_SRA:    begin p = 64'(sa >>> sh); e.res = p[31:0]; end
            C_OP_SLT:    e.res = (sa < sb) ? 32'd1 : 32'd0;
            C_OP_SLTU:   e.res = (a < b) ? 32'd1 : 32'd0;
            C_OP_MUL:    begin p = {32'h0, a} * {32'h0, b}; e.res = p[31:0];  e.lat = W + 1; end
            C_OP_MULH:   begin p = 64'(sa * sb);            e.res = p[63:32]; e.lat = W + 1; end
            C_OP_MULHSU: begin p = 64'(sa * longint'({32'h0, b})); e.res = p[63:32]; e.lat = W + 1; end
            C_OP_MULHU:  begin p = {32'h0, a} * {32'h0, b}; e.res = p[63:32]; e.lat = W + 1; end
`ifdef SEQ_ALU_DIV_EN
            C_OP_DIV, C_OP_DIVU, C_OP_REM, C_OP_REMU: begin
                if (b == 0) begin
                    e.res = ((op == C_OP_DIV) || (op == C_OP_DIVU)) ? 32'hFFFF_FFFF : a;
                end else if (((op == C_OP_DIV) || (op == C_OP_REM)) &&
                             (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                    e.res = (op == C_OP_DIV) ? a : 32'h0;
                end else begin
                    e.lat = W + 1;
                    case (op)
                        C_OP_DIV:  p = 64'(sa / sb);
                        C_OP_REM:  p = 64'(sa % sb);
                        C_OP_DIVU: p = {32'h0, a / b};
                        default:   p = {32'h0, a % b};
                    endcase
                    e.res = p[31:0];
                end
            end
`endif
            default:     e.ill = 1'b1;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    // Raises in_valid at once and holds it until in_ready is seen at an edge
    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   t;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        t = 0;
        while (!bus.in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1 within 500 cycles");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e     = model(op, a, b);
        e.acc = cyc;
        q.push_back(e);
        bus.in_valid = 1'b0;
        bus.op       = 5'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        end
        repeat (8) @(negedge clk);
    endtask

    // Monitor: pops on the first cycle of each result, checks hold under backpressure
    exp_t         m_exp;
    logic [W-1:0] m_held;
    logic         m_seen  = 1'b0;
    int           m_stall = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_seen        = 1'b0;
            bus.out_ready = 1'b0;
        end else begin
            if (bus.out_ready) m_seen = 1'b0;
            if (bus.out_valid) begin
                if (!m_seen) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_output: got result %h, expected no output", bus.result);
                    end else begin
                        m_exp = q.pop_front();
                        chk("result",  bus.result, m_exp.res);
                        chk("zero",    W'(bus.zero), W'(m_exp.zero));
                        chk("illegal", W'(bus.illegal), W'(m_exp.ill));
                        chk("latency", W'(cyc - m_exp.acc + 1), W'(m_exp.lat));
                    end
                    m_held  = bus.result;
                    m_seen  = 1'b1;
                    m_stall = (stall_next != 0) ? 5 : int'($urandom_range(0, 2));
                end else begin
                    chk("hold_result",   bus.result, m_held);
                    chk("hold_in_ready", W'(bus.in_ready), W'(0));
                end
                if (m_stall > 0) begin
                    bus.out_ready = 1'b0;
                    m_stall--;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end else begin
                bus.out_ready = 1'b0;
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.a        = '0;
        bus.b        = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  W'(bus.in_ready),  W'(1));
        chk("rst_out_valid", W'(bus.out_valid), W'(0));
        chk("rst_result",    bus.result,        W'(0));
        chk("rst_zero",      W'(bus.zero),      W'(0));
        chk("rst_illegal",   W'(bus.illegal),   W'(0));
        rst_n = 1'b1;

        issue(C_OP_ADD,   32'h7FFF_FFFF, 32'h1);
        issue(C_OP_SUB,   32'd5,         32'd5);
        issue(C_OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(C_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(C_OP_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(C_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        issue(C_OP_REM,   32'h8000_0000, 32'hFFFF_FFFF);
        issue(C_OP_DIV,   32'hFFFF_FFF9, 32'd2);
        issue(C_OP_REM,   32'hFFFF_FFF9, 32'd2);
        issue(C_OP_DIVU,  32'd7,         32'd0);
        issue(C_OP_REMU,  32'd7,         32'd0);
        issue(C_OP_SRA,   32'h8000_00F0, 32'h0000_0104);
        issue(C_OP_SLT,   32'hFFFF_FFFF, 32'd1);
        issue(5'd25,      32'd3,         32'd4);
        drain();

        stall_next = 1;
        issue(C_OP_ADD, 32'd1234, 32'd4321);
        issue(C_OP_XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
        drain();
        stall_next = 0;

        for (int i = 0; i < 150; i++)
            issue(5'($urandom_range(0, 19)), rnd(), rnd());
        drain();

        issue(C_OP_MUL, 32'($urandom), 32'($urandom));
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready",  W'(bus.in_ready),  W'(1));
        chk("abort_out_valid", W'(bus.out_valid), W'(0));
        chk("abort_result",    bus.result,        W'(0));
        chk("abort_zero",      W'(bus.zero),      W'(0));
        chk("abort_illegal",   W'(bus.illegal),   W'(0));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(C_OP_ADD, 32'd2, 32'd3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
